// File: rtl/kbd_text_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kbd_pkg
// Purpose : Shared constants for the keyboard text buffer. Holds the PS/2
//           set-2 scan codes that act as editing commands, the blank
//           character, and the two-state controller encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package kbd_pkg;

  // Non-extended command codes
  localparam logic [7:0] KC_BKSP     = 8'h66;
  localparam logic [7:0] KC_ENTER    = 8'h5A;
  localparam logic [7:0] KC_ESC      = 8'h76;
  // E0-extended command codes
  localparam logic [7:0] KC_LEFT     = 8'h6B;
  localparam logic [7:0] KC_RIGHT    = 8'h74;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Controller states
  localparam logic [0:0] ST_CLEAR    = 1'b0;
  localparam logic [0:0] ST_IDLE     = 1'b1;

endpackage
`default_nettype wire

// File: rtl/kbd_text_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : kbd_text_buffer_if
// Purpose : Bundles the key-event strobe, the display read port and the
//           status outputs of the text buffer.
// Ports   : master drives key_valid/key_make/key_ext/keycode/ascii/rd_addr
//           and observes rd_data/cursor/busy/full; slave is the buffer side.
// Revision: 1.0 - initial release
// ============================================================================
interface kbd_text_buffer_if #(
  parameter int AW = 5
);
  logic          key_valid;
  logic          key_make;
  logic          key_ext;
  logic [7:0]    keycode;
  logic [7:0]    ascii;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [AW-1:0] cursor;
  logic          busy;
  logic          full;

  modport master (
    output key_valid, key_make, key_ext, keycode, ascii, rd_addr,
    input  rd_data, cursor, busy, full
  );

  modport slave (
    input  key_valid, key_make, key_ext, keycode, ascii, rd_addr,
    output rd_data, cursor, busy, full
  );
endinterface
`default_nettype wire

// File: rtl/kbd_text_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module  : text_ram
// Purpose : Simple dual-port 8-bit character store. Synchronous write,
//           registered read with read-before-write behaviour on a same-address
//           collision. Addresses past the last word read back as a space.
// Ports   : clk, reset_n (resets the read register only), we_i/waddr_i/
//           wdata_i write port, raddr_i read address, rdata_o read data.
// Revision: 1.0 - initial release
// ============================================================================
module text_ram
  import kbd_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= ASCII_SPACE;
    end else if ({1'b0, raddr_i} >= c_DEPTH) begin
      rdata_q <= ASCII_SPACE;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/kbd_text_buffer.sv
`default_nettype none
// ============================================================================
// Module  : kbd_text_buffer
// Purpose : Character-cell text buffer fed by decoded PS/2 key events.
//           Printable keys are written at the cursor; Backspace, Enter, Esc
//           and the extended arrow keys edit or move the cursor. Reset and Esc
//           blank the whole buffer with a one-cell-per-cycle sweep.
// Ports   : clk, reset_n (sync, active low), bus (slave side of
//           kbd_text_buffer_if: key events in, display read port and
//           cursor/busy/full status out).
// Revision: 1.0 - initial release
// ============================================================================
module kbd_text_buffer
  import kbd_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 2,
  parameter int WRAP = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  kbd_text_buffer_if.slave  bus
);

  localparam int          DEPTH   = COLS * ROWS;
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);
  localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
  localparam logic          c_WRAP  = (WRAP != 0);

  logic [0:0]    state_q,  state_d;
  logic [AW-1:0] sweep_q,  sweep_d;
  logic [AW-1:0] cursor_q, cursor_d;
  logic          full_q,   full_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          key_accept;
  logic [AW:0]   next_row;

  assign key_accept = bus.key_valid && bus.key_make;

  // Start of the row below the cursor; may equal DEPTH on the last row.
  assign next_row = (AW+1)'((int'(cursor_q) / COLS + 1) * COLS);

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    cursor_d = cursor_q;
    full_d   = full_q;
    we       = 1'b0;
    waddr    = cursor_q;
    wdata    = ASCII_SPACE;

    if (state_q == ST_CLEAR) begin
      // The sweep owns the write port; key events are dropped meanwhile.
      we    = 1'b1;
      waddr = sweep_q;
      if (sweep_q == c_LAST) begin
        state_d = ST_IDLE;
        sweep_d = '0;
      end else begin
        sweep_d = sweep_q + AW'(1);
      end
    end else if (key_accept) begin
      if (bus.key_ext) begin
        if (bus.keycode == KC_LEFT) begin
          full_d = 1'b0;
          if (cursor_q != '0) cursor_d = cursor_q - AW'(1);
        end else if (bus.keycode == KC_RIGHT) begin
          full_d = 1'b0;
          if (cursor_q != c_LAST) cursor_d = cursor_q + AW'(1);
        end
      end else begin
        case (bus.keycode)
          KC_BKSP: begin
            full_d = 1'b0;
            if (cursor_q != '0) begin
              cursor_d = cursor_q - AW'(1);
              we       = 1'b1;
              waddr    = cursor_q - AW'(1);
            end
          end
          KC_ENTER: begin
            if (next_row < c_DEPTH) begin
              cursor_d = next_row[AW-1:0];
            end else if (c_WRAP) begin
              cursor_d = '0;
            end
          end
          KC_ESC: begin
            cursor_d = '0;
            full_d   = 1'b0;
            state_d  = ST_CLEAR;
            sweep_d  = '0;
          end
          default: begin
            if (bus.ascii != 8'h00 && !full_q) begin
              we    = 1'b1;
              wdata = bus.ascii;
              if (cursor_q == c_LAST) begin
                // Without wrap the cursor parks on the last cell and locks.
                if (c_WRAP) cursor_d = '0;
                else        full_d   = 1'b1;
              end else begin
                cursor_d = cursor_q + AW'(1);
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_CLEAR;
      sweep_q  <= '0;
      cursor_q <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      cursor_q <= cursor_d;
      full_q   <= full_d;
    end
  end

  // Writes are suppressed during reset so a key strobe coincident with
  // reset cannot leave a character behind.
  text_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (we && reset_n),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

  assign bus.cursor = cursor_q;
  assign bus.busy   = (state_q == ST_CLEAR);
  assign bus.full   = full_q;

endmodule
`default_nettype wire

// File: tb/tb_kbd_text_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_kbd_text_buffer
// Purpose : Self-checking bench for kbd_text_buffer. Two instances (index 0
//           without wrap, index 1 with wrap) share one stimulus stream and are
//           compared every cycle against an array-based reference model;
//           directed sequences add literal expectations.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_kbd_text_buffer;
  import kbd_pkg::*;

  localparam int COLS  = 16;
  localparam int ROWS  = 2;
  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          key_valid, key_make, key_ext;
  logic [7:0]    keycode, ascii;
  logic [AW-1:0] rd_addr;

  always #5 clk = ~clk;

  kbd_text_buffer_if #(.AW(AW)) bus0 ();
  kbd_text_buffer_if #(.AW(AW)) bus1 ();

  assign bus0.key_valid = key_valid;  assign bus1.key_valid = key_valid;
  assign bus0.key_make  = key_make;   assign bus1.key_make  = key_make;
  assign bus0.key_ext   = key_ext;    assign bus1.key_ext   = key_ext;
  assign bus0.keycode   = keycode;    assign bus1.keycode   = keycode;
  assign bus0.ascii     = ascii;      assign bus1.ascii     = ascii;
  assign bus0.rd_addr   = rd_addr;    assign bus1.rd_addr   = rd_addr;

  kbd_text_buffer #(.COLS(COLS), .ROWS(ROWS), .WRAP(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0));
  kbd_text_buffer #(.COLS(COLS), .ROWS(ROWS), .WRAP(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));

  logic [7:0]    d_rd   [2];
  logic [AW-1:0] d_cur  [2];
  logic          d_busy [2];
  logic          d_full [2];
  assign d_rd[0] = bus0.rd_data;  assign d_rd[1] = bus1.rd_data;
  assign d_cur[0] = bus0.cursor;  assign d_cur[1] = bus1.cursor;
  assign d_busy[0] = bus0.busy;   assign d_busy[1] = bus1.busy;
  assign d_full[0] = bus0.full;   assign d_full[1] = bus1.full;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model (index k == WRAP setting) ----------------
  logic [7:0] m_mem   [2][DEPTH];
  int         m_cur   [2];
  bit         m_full  [2];
  int         m_clr   [2] = '{-1, -1};   // next cell to blank, -1 when idle
  bit         m_known [2] = '{0, 0};     // every cell has been written once
  logic [7:0] m_rd    [2];
  bit         m_rd_ok [2] = '{0, 0};
  bit         started = 0;

  task automatic model_key(input int k);
    int nr;
    if (key_ext) begin
      if (keycode == 8'h6B) begin
        m_full[k] = 0;
        if (m_cur[k] > 0) m_cur[k]--;
      end else if (keycode == 8'h74) begin
        m_full[k] = 0;
        if (m_cur[k] < DEPTH - 1) m_cur[k]++;
      end
    end else if (keycode == 8'h66) begin
      m_full[k] = 0;
      if (m_cur[k] > 0) begin
        m_cur[k]--;
        m_mem[k][m_cur[k]] = 8'h20;
      end
    end else if (keycode == 8'h5A) begin
      nr = (m_cur[k] / COLS + 1) * COLS;
      if (nr < DEPTH) m_cur[k] = nr;
      else if (k == 1) m_cur[k] = 0;
    end else if (keycode == 8'h76) begin
      m_cur[k] = 0; m_full[k] = 0; m_clr[k] = 0;
    end else if (ascii != 8'h00 && !m_full[k]) begin
      m_mem[k][m_cur[k]] = ascii;
      if (m_cur[k] == DEPTH - 1) begin
        if (k == 1) m_cur[k] = 0;
        else m_full[k] = 1;
      end else m_cur[k]++;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_rd_ok[k] = m_known[k] || !reset_n;
      m_rd[k]    = (!reset_n || int'(rd_addr) >= DEPTH) ? 8'h20 : m_mem[k][rd_addr];
      if (!reset_n) begin
        m_cur[k] = 0; m_full[k] = 0; m_clr[k] = 0;
      end else if (m_clr[k] >= 0) begin
        m_mem[k][m_clr[k]] = 8'h20;
        if (m_clr[k] == DEPTH - 1) begin
          m_clr[k] = -1; m_known[k] = 1;
        end else m_clr[k]++;
      end else if (key_valid && key_make) begin
        model_key(k);
      end
    end
    if (!reset_n) started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cursor[%0d]", k), 32'(d_cur[k]), 32'(m_cur[k]));
        chk($sformatf("busy[%0d]", k), 32'(d_busy[k]), 32'(m_clr[k] >= 0));
        chk($sformatf("full[%0d]", k), 32'(d_full[k]), 32'(m_full[k]));
        if (m_rd_ok[k]) chk($sformatf("rd_data[%0d]", k), 32'(d_rd[k]), 32'(m_rd[k]));
      end
    end
  end

  // ---------------- directed helpers (called at posedge + 1) ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic key(input bit ext, input logic [7:0] code, input logic [7:0] asc,
                     input bit make = 1'b1);
    key_valid = 1'b1; key_make = make; key_ext = ext; keycode = code; ascii = asc;
    tick;
    key_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while ((d_busy[0] || d_busy[1]) && n < 200) begin
      tick;
      n++;
    end
  endtask

  task automatic read_cell(input int k, input int addr, output logic [7:0] v);
    rd_addr = AW'(addr);
    tick;
    v = d_rd[k];
  endtask

  logic [7:0] v;
  int         n;

  initial begin
    reset_n = 1'b0; key_valid = 1'b0; key_make = 1'b0; key_ext = 1'b0;
    keycode = 8'h00; ascii = 8'h00; rd_addr = '0;
    #1;
    repeat (3) tick;
    chk("reset_busy", 32'(d_busy[1]), 1);
    chk("reset_rd", 32'(d_rd[0]), 32'h20);
    reset_n = 1'b1;
    chk("reset_cursor", 32'(d_cur[0]), 0);
    wait_idle(n);
    chk("clear_cycles", n, 32);
    read_cell(0, 0, v);  chk("blank_cell0", v, 32'h20);
    read_cell(1, 31, v); chk("blank_cell31", v, 32'h20);

    // Type 'A','B' plus their breaks
    key(0, 8'h1C, 8'h41); key(0, 8'h32, 8'h42);
    key(0, 8'h1C, 8'h41, 1'b0); key(0, 8'h32, 8'h42, 1'b0);
    chk("ab_cursor", 32'(d_cur[0]), 2);
    read_cell(1, 0, v); chk("cell0_A", v, 32'h41);
    read_cell(0, 1, v); chk("cell1_B", v, 32'h42);
    read_cell(1, 2, v); chk("cell2_blank", v, 32'h20);

    // Backspace from 5
    key(1, KC_RIGHT, 8'h00); key(1, KC_RIGHT, 8'h00);
    key(0, 8'h21, 8'h43);
    chk("c_cursor", 32'(d_cur[1]), 5);
    key(0, KC_BKSP, 8'h00);
    chk("bksp_cursor", 32'(d_cur[1]), 4);
    read_cell(1, 4, v); chk("bksp_cell4", v, 32'h20);
    repeat (6) key(1, KC_LEFT, 8'h00);
    key(0, KC_BKSP, 8'h00);
    chk("bksp_at0", 32'(d_cur[0]), 0);
    read_cell(0, 0, v); chk("bksp_at0_cell", v, 32'h41);

    // Enter
    repeat (3) key(1, KC_RIGHT, 8'h00);
    key(0, KC_ENTER, 8'h00);
    chk("enter_row1", 32'(d_cur[1]), 16);
    key(0, KC_ENTER, 8'h00);
    chk("enter_last_wrap", 32'(d_cur[1]), 0);
    chk("enter_last_hold", 32'(d_cur[0]), 16);

    // Esc with a key during the sweep
    key(0, KC_ESC, 8'h00);
    key(0, 8'h22, 8'h58);
    wait_idle(n);
    chk("esc_clear_cycles", n + 1, 32);
    chk("esc_cursor", 32'(d_cur[0]), 0);
    read_cell(0, 0, v); chk("esc_cell0", v, 32'h20);

    // Fill the whole buffer
    for (int i = 0; i < 32; i++) key(0, 8'h1C, 8'(8'h61 + i % 26));
    chk("fill_wrap_cursor", 32'(d_cur[1]), 0);
    chk("fill_hold_cursor", 32'(d_cur[0]), 31);
    chk("fill_full", 32'(d_full[0]), 1);
    key(0, 8'h1A, 8'h5A);
    read_cell(0, 31, v); chk("full_cell31", v, 32'h66);
    read_cell(1, 0, v);  chk("wrap_cell0", v, 32'h5A);
    key(1, KC_LEFT, 8'h00);
    chk("left_clears_full", 32'(d_full[0]), 0);
    chk("left_cursor", 32'(d_cur[0]), 30);

    // Same-address read and write
    key(0, KC_ESC, 8'h00);
    wait_idle(n);
    rd_addr = '0;
    key(0, 8'h15, 8'h51);
    chk("rw_old", 32'(d_rd[1]), 32'h20);
    tick;
    chk("rw_new", 32'(d_rd[1]), 32'h51);

    // Reset coincident with a key
    reset_n = 1'b0;
    key(0, 8'h2D, 8'h52);
    tick;
    reset_n = 1'b1;
    wait_idle(n);
    chk("rst_clear_cycles", n, 32);
    read_cell(1, 0, v); chk("rst_cell0", v, 32'h20);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int sel;
      reset_n   = ($urandom_range(0, 599) != 0);
      key_valid = ($urandom_range(0, 1) == 1);
      key_make  = ($urandom_range(0, 4) != 0);
      key_ext   = ($urandom_range(0, 3) == 0);
      sel       = $urandom_range(0, 15);
      case (sel)
        0, 1:    keycode = KC_BKSP;
        2:       keycode = KC_ENTER;
        3:       keycode = ($urandom_range(0, 7) == 0) ? KC_ESC : 8'h1C;
        4, 5:    keycode = KC_LEFT;
        6, 7:    keycode = KC_RIGHT;
        default: keycode = 8'($urandom_range(0, 255));
      endcase
      if (keycode == KC_ESC && !key_ext && sel != 3) keycode = 8'h1C;
      ascii   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(32, 126));
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      tick;
    end
    key_valid = 1'b0;
    reset_n   = 1'b1;
    repeat (40) tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kbd_text_buffer.md
KBD_TEXT_BUFFER -- requirements
Module: kbd_text_buffer

Interface
REQ-001 Parameter COLS, default 16, characters per row (>=2).
REQ-002 Parameter ROWS, default 2, number of rows (>=1); DEPTH = COLS*ROWS, AW = clog2(DEPTH) derived as localparams.
REQ-003 Parameter WRAP, default 1; 1 = cursor wraps from last cell to cell 0; 0 = cursor holds at last cell and buffer reports full.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 key_valid  in  1  one-cycle strobe: keycode/ascii/key_make/key_ext valid this cycle.
REQ-007 key_make  in  1  1 = make (press), 0 = break (release).
REQ-008 key_ext  in  1  1 = E0-extended keycode.
REQ-009 keycode  in  8  PS/2 set-2 scan code.
REQ-010 ascii  in  8  translated character; 0x00 = non-printable.
REQ-011 rd_addr  in  AW  display read address (row-major, row*COLS+col).
REQ-012 rd_data  out  8  character at rd_addr, registered.
REQ-013 cursor  out  AW  current write position.
REQ-014 busy  out  1  1 while clear sweep runs; key events ignored.
REQ-015 full  out  1  WRAP=0 only: last cell written, printable keys rejected.

Function
REQ-016 States CLEAR and IDLE; CLEAR writes 0x20 to address sweep_idx each cycle, sweep_idx 0..DEPTH-1, then IDLE; busy=1 exactly while in CLEAR.
REQ-017 Events processed only when key_valid=1, key_make=1 and state IDLE; break events and events during CLEAR are dropped without side effect.
REQ-018 key_ext=0, keycode 0x66 (Backspace): if cursor>0, cursor-1 and write 0x20 at new cursor; at cursor 0 no-op; full cleared.
REQ-019 key_ext=0, keycode 0x5A (Enter): cursor to column 0 of next row; on last row: WRAP=1 -> cursor 0, WRAP=0 -> no change.
REQ-020 key_ext=0, keycode 0x76 (Esc): cursor 0, full 0, enter CLEAR with sweep_idx 0.
REQ-021 key_ext=1, keycode 0x6B (Left): cursor-1 saturating at 0; 0x74 (Right): cursor+1 saturating at DEPTH-1; both clear full; other extended codes ignored.
REQ-022 Other codes with ascii!=0: write ascii at cursor; cursor+1; at DEPTH-1: WRAP=1 -> cursor 0; WRAP=0 -> cursor holds, full set; while full=1 printables are not written.
REQ-023 Other codes with ascii=0 ignored.
REQ-024 Buffer update (write and cursor) visible on outputs the cycle after the accepted strobe.
REQ-025 rd_data latency 1 cycle; same-address read/write in one cycle returns old data; rd_addr>=DEPTH returns 0x20.
REQ-026 Write port is single; at most one write per cycle (sweep or key, never both).

Reset
REQ-027 While reset_n=0 at a clock edge: state CLEAR, sweep_idx 0, cursor 0, full 0, rd_data 0x20, busy 1.
REQ-028 After release, CLEAR completes in DEPTH cycles; busy deasserts on cycle DEPTH.
REQ-029 Reset asserted mid-sweep or mid-edit restarts sweep from 0; no partial key effect persists.

Structure
REQ-030 Shared package kbd_pkg: keycode constants KC_BKSP 0x66, KC_ENTER 0x5A, KC_ESC 0x76, KC_LEFT 0x6B, KC_RIGHT 0x74, ASCII_SPACE 0x20, state encoding.
REQ-031 One sub-module text_ram: parametrised simple dual-port RAM, 8-bit, DEPTH words, sync write, registered read.

Verification
REQ-032 Reset, COLS=16 ROWS=2 -> busy=1 for 32 cycles; all rd_data 0x20; cursor 0.
REQ-033 Type 'A','B' (ascii 0x41,0x42) then break codes -> cells 0,1 = 0x41,0x42, cursor 2; breaks change nothing.
REQ-034 cursor 5, Backspace -> cursor 4, cell 4 = 0x20; at cursor 0 Backspace -> no change.
REQ-035 WRAP=1, 32 printables -> cursor 0 after 32nd; WRAP=0 -> cursor 31, full=1, 33rd key leaves cell 31 unchanged; Left clears full, cursor 30.
REQ-036 Cursor 3, Enter -> 16; Enter on row 1 -> 0 (WRAP=1) or 16.. unchanged (WRAP=0); Esc -> busy 32 cycles, keys during busy dropped.
REQ-037 Key strobe and rd_addr same cell same cycle -> old value, new value next read.
